// File: rtl/pixel_arb_pkg.sv
// rtl/pixel_arb_pkg.sv - shared widths, screen bounds and FSM state type for the pixel write arbiter
package pixel_arb_pkg;

  localparam int COORD_W  = 15;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// rtl/pixel_write_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - merges per-tower pixel bursts onto one registered VGA write port
// Optional off-screen pixel suppression with PIXEL_CLIP_EN.
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [COORD_W*N_REQ-1:0]  req_coords,
  input  logic [COLOUR_W*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]          req_ready,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [N_REQ-1:0]   owner_oh;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [CNT_W-1:0]   stall_cnt;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               accept;
  logic               revoke;
  logic               own_valid;
  logic               own_last;
  logic [COORD_W-1:0] own_coords;
  logic [COLOUR_W-1:0] own_colour;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic               plot_ok;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    own_valid  = req_valid[owner];
    own_last   = req_last[owner];
    own_coords = req_coords[int'(owner)*COORD_W +: COORD_W];
    own_colour = req_colour[int'(owner)*COLOUR_W +: COLOUR_W];
  end

  assign own_x    = own_coords[COORD_W-1 -: X_W];
  assign own_y    = own_coords[Y_W-1:0];
  assign next_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef PIXEL_CLIP_EN
  assign plot_ok = in_screen(own_x, own_y);
`else
  assign plot_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Revocation takes priority over the owner's beat so no pixel leaks on the timeout cycle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    revoke    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) state_nxt = ARB_BURST;
      end
      ARB_BURST: begin
        if (stall_cnt == CNT_W'(IDLE_TIMEOUT)) begin
          revoke    = 1'b1;
          state_nxt = ARB_IDLE;
        end else begin
          req_ready = owner_oh;
          accept    = own_valid;
          if (own_valid && own_last) state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner       <= '0;
      owner_oh    <= '0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (state == ARB_IDLE) begin
      stall_cnt <= '0;
      if (pick_any) begin
        owner    <= pick_idx;
        owner_oh <= pick_grant;
      end
    end else if (revoke) begin
      rr_ptr      <= next_ptr;
      stall_cnt   <= '0;
      timeout_err <= 1'b1;
    end else if (accept) begin
      stall_cnt <= '0;
      if (own_last) rr_ptr <= next_ptr;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Bus holds the last plotted pixel; clipped pixels never reach the adapter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= accept && plot_ok;
      if (accept && plot_ok) begin
        vga_x      <= own_x;
        vga_y      <= own_y;
        vga_colour <= own_colour;
      end
    end
  end

endmodule
